// File: rtl/module_knob_quad_decoder.sv
// rtl/module_knob_quad_decoder.sv - rotary encoder front end: sync, debounce, quadrature decode, detent counter
module module_knob_quad_decoder #(
  parameter int CNT_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic                 qzt_clk,
  input  logic                 rst,
  input  logic                 rot_A,
  input  logic                 rot_B,
  input  logic                 clear,
  output logic                 pulse,
  output logic                 direction,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 err
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0] SPD = 4'(STEPS_PER_DETENT);
  localparam logic [CNT_WIDTH-1:0] POS_MAX = '1;

  logic [1:0] sync1, sync2, filt, prev;
  logic [DW-1:0] db_cnt [2];
  logic signed [3:0] acc, acc_n, acc_sum;
  logic [CNT_WIDTH-1:0] pos_n;
  logic pulse_n, dir_n, err_n;
  logic [1:0] step;

  // Gray code position around the cycle; CW walks 00->10->11->01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  assign step = phase(filt) - phase(prev);

  always_comb begin
    acc_n   = acc;
    acc_sum = acc;
    pos_n   = position;
    pulse_n = 1'b0;
    dir_n   = 1'b0;
    err_n   = 1'b0;
    case (step)
      2'd1: begin
        acc_sum = acc + 4'sd1;
        if (acc_sum == SPD) begin
          pulse_n = 1'b1;
          dir_n   = 1'b1;
          acc_n   = 4'sd0;
          if (position != POS_MAX) pos_n = position + 1'b1;
          else if (WRAP != 0)      pos_n = '0;
        end else begin
          acc_n = acc_sum;
        end
      end
      2'd3: begin
        acc_sum = acc - 4'sd1;
        if (acc_sum == -SPD) begin
          pulse_n = 1'b1;
          acc_n   = 4'sd0;
          if (position != '0)  pos_n = position - 1'b1;
          else if (WRAP != 0)  pos_n = POS_MAX;
        end else begin
          acc_n = acc_sum;
        end
      end
      2'd2: begin
        err_n = 1'b1;
        acc_n = 4'sd0;
      end
      default: ;
    endcase
    // clear still lets a coincident detent strobe out, but position lands on 0
    if (clear) begin
      pos_n = '0;
      acc_n = 4'sd0;
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      filt      <= 2'b11;
      prev      <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      acc       <= 4'sd0;
      position  <= '0;
      pulse     <= 1'b0;
      direction <= 1'b0;
      err       <= 1'b0;
    end else begin
      sync1 <= {rot_A, rot_B};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      prev      <= filt;
      acc       <= acc_n;
      position  <= pos_n;
      pulse     <= pulse_n;
      direction <= dir_n;
      err       <= err_n;
    end
  end

endmodule
